// File: rtl/cnt_reader_pkg.sv
// -----------------------------------------------------------------------------
// cnt_reader_pkg
// Shared definitions for the vision accumulator array and its snapshot reader:
// default array geometry, the frame-state value that triggers a capture, and
// the reader FSM encoding.
// -----------------------------------------------------------------------------
package cnt_reader_pkg;

  // Default accumulator array geometry
  localparam int DEF_MODN = 30;
  localparam int DEF_ADDW = 14;
  localparam int DEF_IDXW = 5;

  // Frame state in which the accumulator array holds a finished frame
  localparam logic [1:0] CAP_STATE = 2'b11;

  // Reader FSM encoding
  localparam logic [1:0] FSM_IDLE   = 2'd0;
  localparam logic [1:0] FSM_STREAM = 2'd1;
  localparam logic [1:0] FSM_DONE   = 2'd2;

  // A capture is the first cycle the frame state enters CAP_STATE
  function automatic logic is_capture(input logic [1:0] st, input logic [1:0] st_q);
    return (st == CAP_STATE) && (st_q != CAP_STATE);
  endfunction

endpackage

// File: rtl/cnt_reader_if.sv
// -----------------------------------------------------------------------------
// cnt_reader_if
// Valid/ready stream carrying one channel count per beat.
//   out_valid  source -> sink  beat fields are valid
//   out_ready  sink -> source  sink accepts the beat this cycle
//   out_data   source -> sink  channel count (ADDW bits, unsigned)
//   out_idx    source -> sink  channel index (IDXW bits)
//   out_last   source -> sink  beat carries the final channel
// -----------------------------------------------------------------------------
interface cnt_reader_if
  import cnt_reader_pkg::*;
#(
  parameter int ADDW = DEF_ADDW,
  parameter int IDXW = DEF_IDXW
) ();

  logic            out_valid;
  logic            out_ready;
  logic [ADDW-1:0] out_data;
  logic [IDXW-1:0] out_idx;
  logic            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/cnt_reader_argmax.sv
// -----------------------------------------------------------------------------
// cnt_argmax
// Running maximum over a stream of unsigned counts. The first element of a
// frame loads unconditionally; later elements replace the maximum only when
// strictly greater, so the lowest index wins a tie.
//   clk, rst         clock, synchronous active-high reset
//   first            current element is the first of the frame
//   valid            current element is consumed this cycle
//   data, idx        current element value and channel index
//   max_val, max_idx running maximum and its channel
// -----------------------------------------------------------------------------
module cnt_argmax #(
  parameter int ADDW = 14,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            first,
  input  logic            valid,
  input  logic [ADDW-1:0] data,
  input  logic [IDXW-1:0] idx,
  output logic [ADDW-1:0] max_val,
  output logic [IDXW-1:0] max_idx
);

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (valid && (first || (data > max_val))) begin
      max_val <= data;
      max_idx <= idx;
    end
  end

endmodule

// File: rtl/cnt_reader.sv
// -----------------------------------------------------------------------------
// cnt_reader
// Snapshots the accumulator array when a frame completes and streams the
// channel counts out one per handshake, reporting the largest count and its
// channel once the frame has been fully streamed.
//   clk, rst      clock, synchronous active-high reset
//   state         frame state shared with the accumulator array
//   cnt_bus       packed channel counts, channel i at [i*ADDW +: ADDW]
//   out_if        valid/ready count stream (master side)
//   max_val/idx   largest count of the last completed frame and its channel
//   result_valid  one-cycle pulse when max_val/max_idx update
//   busy          a snapshot is being streamed or finalised
//   overrun       sticky: a capture arrived while busy and was dropped
// -----------------------------------------------------------------------------
module cnt_reader
  import cnt_reader_pkg::*;
#(
  parameter int MODN = DEF_MODN,
  parameter int ADDW = DEF_ADDW,
  parameter int IDXW = DEF_IDXW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           state,
  input  logic [MODN*ADDW-1:0] cnt_bus,
  cnt_reader_if.master         out_if,
  output logic [ADDW-1:0]      max_val,
  output logic [IDXW-1:0]      max_idx,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MODN - 1);

  logic [1:0]      state_q;
  logic [1:0]      fsm;
  logic [IDXW-1:0] idx;
  logic [ADDW-1:0] shadow [MODN];
  logic [ADDW-1:0] max_val_q;
  logic [IDXW-1:0] max_idx_q;
  logic [ADDW-1:0] run_val;
  logic [IDXW-1:0] run_idx;
  logic [ADDW-1:0] cur_data;
  logic            capture;
  logic            streaming;
  logic            at_last;
  logic            hs;

  assign capture   = is_capture(state, state_q);
  assign streaming = (fsm == FSM_STREAM);
  assign at_last   = (idx == LAST_IDX);
  assign hs        = streaming && out_if.out_ready;
  assign cur_data  = shadow[idx];

  // ---- capture edge detect ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= 2'b00;
    else     state_q <= state;
  end

  // ---- frame control: IDLE -> STREAM -> DONE -> IDLE ----
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= FSM_IDLE;
      idx <= '0;
    end else begin
      case (fsm)
        FSM_IDLE: begin
          if (capture) begin
            fsm <= FSM_STREAM;
            idx <= '0;
          end
        end
        FSM_STREAM: begin
          if (hs) begin
            if (at_last) begin
              fsm <= FSM_DONE;
              idx <= '0;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        FSM_DONE: fsm <= FSM_IDLE;
        default:  fsm <= FSM_IDLE;
      endcase
    end
  end

  // Captures outside IDLE are dropped so the snapshot stays coherent
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MODN; i++) shadow[i] <= '0;
    end else if ((fsm == FSM_IDLE) && capture) begin
      for (int i = 0; i < MODN; i++) shadow[i] <= cnt_bus[i*ADDW +: ADDW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                             overrun <= 1'b0;
    else if (capture && (fsm != FSM_IDLE)) overrun <= 1'b1;
  end

  // ---- stream output ----
  // Outputs come straight from the held index, so a stall keeps them stable
  assign out_if.out_valid = streaming;
  assign out_if.out_data  = streaming ? cur_data : '0;
  assign out_if.out_idx   = streaming ? idx : '0;
  assign out_if.out_last  = streaming && at_last;

  // ---- running maximum ----
  cnt_argmax #(
    .ADDW (ADDW),
    .IDXW (IDXW)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .first   (idx == '0),
    .valid   (hs),
    .data    (cur_data),
    .idx     (idx),
    .max_val (run_val),
    .max_idx (run_idx)
  );

  // ---- frame result ----
  // The running maximum is final during DONE; it is presented through a bypass
  // that cycle so result_valid and the new values coincide, then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (fsm == FSM_DONE) begin
      max_val_q <= run_val;
      max_idx_q <= run_idx;
    end
  end

  assign result_valid = (fsm == FSM_DONE);
  assign max_val      = result_valid ? run_val : max_val_q;
  assign max_idx      = result_valid ? run_idx : max_idx_q;
  assign busy         = (fsm != FSM_IDLE);

endmodule

// File: tb/tb_cnt_reader.sv
// -----------------------------------------------------------------------------
// tb_cnt_reader
// Directed bench for cnt_reader: a table of frames (fill pattern, ready
// pattern, expected maximum) plus hand-written sequences for reset, snapshot
// isolation, overrun and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_cnt_reader;

  localparam int MODN = 30;
  localparam int ADDW = 14;
  localparam int IDXW = 5;

  typedef struct {
    int pat;       // cnt_bus fill pattern
    int rdy;       // 0: ready always 1, 1: ready 1,0,0,1 repeating
    int exp_mval;
    int exp_midx;
  } frame_vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           state;
  logic [MODN*ADDW-1:0] cnt_bus;
  logic [ADDW-1:0]      max_val;
  logic [IDXW-1:0]      max_idx;
  logic                 result_valid;
  logic                 busy;
  logic                 overrun;

  int checks   = 0;
  int failures = 0;
  int exp_data [MODN];
  int exp_mval;
  int exp_midx;
  frame_vec_t vecs [7];

  always #5 clk = ~clk;

  cnt_reader_if #(.ADDW(ADDW), .IDXW(IDXW)) sif ();

  cnt_reader #(
    .MODN (MODN),
    .ADDW (ADDW),
    .IDXW (IDXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .cnt_bus      (cnt_bus),
    .out_if       (sif),
    .max_val      (max_val),
    .max_idx      (max_idx),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void fill(input int pat);
    for (int i = 0; i < MODN; i++) begin
      int v;
      case (pat)
        0:       v = 100 + i;
        1:       v = (i == 3 || i == 17) ? 16383 : 0;
        2:       v = 0;
        3:       v = 500 - i;
        4:       v = (i == 28 || i == 29) ? 6 : 5;
        default: v = (i == 0) ? 16382 : ((i == 29) ? 16383 : 1);
      endcase
      exp_data[i] = v;
      cnt_bus[i*ADDW +: ADDW] = ADDW'(v);
    end
  endfunction

  // Produces a 00 -> 11 transition; returns #1 after the capture edge
  task automatic do_capture();
    state = 2'b00;
    @(posedge clk); #1;
    state = 2'b11;
    @(posedge clk); #1;
  endtask

  // Consumes one streamed frame starting #1 after the capture edge
  task automatic run_stream(input int rdy, input bit scramble, input bit ovr);
    int beats, k, post, pulses, ovr_ph, done_k, got_mval, got_midx;
    logic [ADDW-1:0] pd;
    logic [IDXW-1:0] pi;
    logic            pl;
    bit              pstall;
    beats = 0; k = 0; post = 0; pulses = 0; ovr_ph = 0; done_k = -1;
    got_mval = -1; got_midx = -1; pstall = 0; pd = '0; pi = '0; pl = 1'b0;
    while (post < 4 && k < 400) begin
      sif.out_ready = (rdy == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (scramble) cnt_bus = ~cnt_bus;
      if (ovr) begin
        if (ovr_ph == 0 && beats == 10) begin state = 2'b00; ovr_ph = 1; end
        else if (ovr_ph == 1)           begin state = 2'b11; ovr_ph = 2; end
      end
      @(negedge clk);
      if (pstall) begin
        chk("stall_valid", sif.out_valid, 1);
        chk("stall_data", sif.out_data, pd);
        chk("stall_idx", sif.out_idx, pi);
        chk("stall_last", sif.out_last, pl);
      end
      if (sif.out_valid && sif.out_ready) begin
        if (beats < MODN) begin
          chk("beat_idx", sif.out_idx, beats);
          chk("beat_data", sif.out_data, exp_data[beats]);
          chk("beat_last", sif.out_last, (beats == MODN - 1) ? 1 : 0);
        end
        beats++;
      end
      pstall = sif.out_valid && !sif.out_ready;
      pd = sif.out_data; pi = sif.out_idx; pl = sif.out_last;
      if (result_valid) begin
        pulses++;
        done_k   = k;
        got_mval = max_val;
        got_midx = max_idx;
      end
      if (beats >= MODN) post++;
      @(posedge clk); #1;
      k++;
    end
    chk("beat_count", beats, MODN);
    chk("rv_pulses", pulses, 1);
    chk("done_cycle", done_k, (rdy == 1) ? 60 : 30);
    chk("max_val", got_mval, exp_mval);
    chk("max_idx", got_midx, exp_midx);
    @(negedge clk);
    chk("max_val_hold", max_val, exp_mval);
    chk("max_idx_hold", max_idx, exp_midx);
    chk("idle_busy", busy, 0);
    chk("idle_valid", sif.out_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int beats;
    int budget;
    int rv_seen;

    vecs[0] = '{0, 0, 129,   29};
    vecs[1] = '{0, 1, 129,   29};
    vecs[2] = '{1, 0, 16383, 3};
    vecs[3] = '{2, 1, 0,     0};
    vecs[4] = '{3, 0, 500,   0};
    vecs[5] = '{4, 1, 6,     28};
    vecs[6] = '{5, 0, 16383, 29};

    // Reset with a capture pending: everything zero, capture discarded
    rst = 1'b1;
    state = 2'b11;
    sif.out_ready = 1'b1;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", sif.out_valid, 0);
    chk("rst_out_last", sif.out_last, 0);
    chk("rst_out_data", sif.out_data, 0);
    chk("rst_out_idx", sif.out_idx, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_max_idx", max_idx, 0);
    rst = 1'b0;
    state = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_capture_dropped_busy", busy, 0);
    chk("rst_capture_dropped_valid", sif.out_valid, 0);
    @(posedge clk); #1;

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].pat);
      exp_mval = vecs[v].exp_mval;
      exp_midx = vecs[v].exp_midx;
      do_capture();
      run_stream(vecs[v].rdy, 1'b0, 1'b0);
    end
    chk("no_overrun_yet", overrun, 0);

    // Snapshot isolation: cnt_bus inverted every cycle after capture
    fill(0);
    exp_mval = 129; exp_midx = 29;
    do_capture();
    run_stream(1, 1'b1, 1'b0);

    // Overrun: second capture at beat 10 is dropped
    fill(4);
    exp_mval = 6; exp_midx = 28;
    do_capture();
    run_stream(0, 1'b0, 1'b1);
    chk("overrun_set", overrun, 1);
    repeat (4) begin
      @(negedge clk);
      chk("overrun_sticky", overrun, 1);
      chk("overrun_no_restream", busy, 0);
      @(posedge clk); #1;
    end

    // Mid-stream reset at beat 12
    fill(0);
    do_capture();
    sif.out_ready = 1'b1;
    beats = 0;
    budget = 0;
    while (beats < 12 && budget < 100) begin
      @(negedge clk);
      if (sif.out_valid && sif.out_ready) beats++;
      budget++;
      @(posedge clk); #1;
    end
    chk("midrst_beats", beats, 12);
    rst = 1'b1;
    state = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", sif.out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_max_val", max_val, 0);
    rv_seen = 0;
    repeat (5) begin
      if (result_valid) rv_seen++;
      @(negedge clk);
    end
    chk("midrst_no_result", rv_seen, 0);
    @(posedge clk); #1;
    fill(3);
    exp_mval = 500; exp_midx = 0;
    do_capture();
    run_stream(0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
